// File: rtl/clk_rst_sequencer.sv
// Power-up / recovery sequencer for the 100MHz->25MHz clock generator: pulses the
// generator reset, waits for a stable lock with timeout/retry, then releases sys_rst_n.
module clk_rst_sequencer #(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int LOCK_TIMEOUT     = 1024,
    parameter int STABLE_CYCLES    = 64,
    parameter int MAX_RETRIES      = 3
) (
    input  logic       i_clk_in,
    input  logic       i_reset_n,
    input  logic       i_pll_locked,
    input  logic       i_soft_reset_req,
    output logic       o_pll_reset,
    output logic       o_sys_rst_n,
    output logic       o_ready,
    output logic       o_fault,
    output logic [3:0] o_retry_count,
    output logic [7:0] o_lock_loss_count
);

    localparam int CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_RST_PULSE = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_retry;
    logic [7:0]         r_loss;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_pll_reset;
    logic               r_sys_rst_n;
    logic               r_ready;
    logic               r_fault;

    state_t             w_next_state;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [3:0]         w_retry_next;
    logic [3:0]         w_retry_inc;
    logic [7:0]         w_loss_next;
    logic               w_counting;

    // Two-flop synchroniser for the asynchronous lock indication.
    always_ff @(posedge i_clk_in or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pll_locked;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state, phase counter, retry and lock-loss bookkeeping.
    always_comb begin
        w_next_state = r_state;
        w_retry_next = r_retry;
        w_loss_next  = r_loss;
        w_retry_inc  = (r_retry < 4'(MAX_RETRIES)) ? (r_retry + 4'd1) : r_retry;

        // Lock loss in RUN is counted even when a soft reset wins the transition.
        if ((r_state == ST_RUN) && !r_sync2 && (r_loss != 8'hFF)) begin
            w_loss_next = r_loss + 8'd1;
        end else begin
            w_loss_next = r_loss;
        end

        if (i_soft_reset_req) begin
            w_next_state = ST_RST_PULSE;
            w_retry_next = 4'd0;
        end else begin
            case (r_state)
                ST_RST_PULSE: begin
                    if (r_cnt == CNT_W'(RST_PULSE_CYCLES - 1)) begin
                        w_next_state = ST_WAIT_LOCK;
                    end else begin
                        w_next_state = ST_RST_PULSE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (r_sync2) begin
                        w_next_state = ST_STABILIZE;
                    end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        w_retry_next = w_retry_inc;
                        if (w_retry_inc == 4'(MAX_RETRIES)) begin
                            w_next_state = ST_FAULT;
                        end else begin
                            w_next_state = ST_RST_PULSE;
                        end
                    end else begin
                        w_next_state = ST_WAIT_LOCK;
                    end
                end
                ST_STABILIZE: begin
                    if (!r_sync2) begin
                        w_next_state = ST_WAIT_LOCK;
                    end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                        w_next_state = ST_RUN;
                        w_retry_next = 4'd0;
                    end else begin
                        w_next_state = ST_STABILIZE;
                    end
                end
                ST_RUN: begin
                    if (!r_sync2) begin
                        w_next_state = ST_RST_PULSE;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    w_next_state = ST_FAULT;
                end
                default: begin
                    w_next_state = ST_RST_PULSE;
                end
            endcase
        end

        w_counting = (r_state == ST_RST_PULSE) || (r_state == ST_WAIT_LOCK) ||
                     (r_state == ST_STABILIZE);
        // A soft reset restarts the pulse even when already pulsing.
        if (i_soft_reset_req || (w_next_state != r_state)) begin
            w_cnt_next = {CNT_W{1'b0}};
        end else if (w_counting) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    // State register with Moore outputs decoded from the state being entered.
    always_ff @(posedge i_clk_in or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_RST_PULSE;
            r_cnt       <= {CNT_W{1'b0}};
            r_retry     <= 4'd0;
            r_loss      <= 8'd0;
            r_pll_reset <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_cnt_next;
            r_retry     <= w_retry_next;
            r_loss      <= w_loss_next;
            r_pll_reset <= (w_next_state == ST_RST_PULSE) || (w_next_state == ST_FAULT);
            r_sys_rst_n <= (w_next_state == ST_RUN);
            r_ready     <= (w_next_state == ST_RUN);
            r_fault     <= (w_next_state == ST_FAULT);
        end
    end

    assign o_pll_reset       = r_pll_reset;
    assign o_sys_rst_n       = r_sys_rst_n;
    assign o_ready           = r_ready;
    assign o_fault           = r_fault;
    assign o_retry_count     = r_retry;
    assign o_lock_loss_count = r_loss;

endmodule
